// File: rtl/fetch_queue.sv
// Instruction fetch stage: decoupled imem request/response, credit-limited
// prefetch queue toward decode. Optional FETCH_BYPASS_EN: empty-queue bypass.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] ins_mem_q [DEPTH];
  logic [XLEN-1:0] ins_mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW:0]     inflight;
  logic [XLEN-1:0] tgt_pc;
  logic req_fire, rsp_keep, head_valid;
  logic byp, byp_take, push, pop;

  assign inflight = {1'b0, count_q} + {1'b0, out_q};
  assign tgt_pc   = redirect_pc & ~XLEN'(3);

  assign imem_req_valid = !rst && !redirect_valid &&
                          (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep   = imem_rsp_valid && (drop_q == '0) &&
                      !redirect_valid;
  assign head_valid = (count_q != '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign byp = rsp_keep && (count_q == '0) && !rst;
`else
  assign byp = 1'b0;
`endif

  assign dec_valid = head_valid || byp;
  assign pop       = head_valid && dec_ready;
  assign byp_take  = byp && dec_ready;
  assign push      = rsp_keep && !byp_take;

  always_comb begin
    dec_pc    = '0;
    dec_instr = '0;
    if (head_valid) begin
      dec_pc    = pc_mem_q[rd_ptr_q];
      dec_instr = ins_mem_q[rd_ptr_q];
    end else if (byp) begin
      dec_pc    = rsp_pc_q;
      dec_instr = imem_rsp_data;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // responses already requested become stale; the one
      // landing this cycle is dropped here, not counted
      fetch_pc_d = tgt_pc;
      rsp_pc_d   = tgt_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + STEP;
      if (push) begin
        pc_mem_d[wr_ptr_q]  = rsp_pc_q;
        ins_mem_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (imem_rsp_valid && (drop_q != '0))
        drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      pc_mem_q   <= '{default: '0};
      ins_mem_q  <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-configurable imem model.
// Expectations follow FETCH_BYPASS_EN when the bench is built with it.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_pc(dec_pc),
    .dec_instr(dec_instr)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] pend_a[$];
  int          pend_due[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_in[$];
  int          pop_cyc[$];
  logic [31:0] req_log[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h13 + ((a - 32'h20) << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int i,
                         input logic [31:0] pc);
    if (i < pop_pc.size()) begin
      chk({tag, " pc"}, pop_pc[i], pc);
      chk({tag, " instr"}, pop_in[i], instr_of(pc));
    end else begin
      chk({tag, " missing"}, 32'(pop_pc.size()), 32'(i + 1));
    end
  endtask

  task automatic half();
    @(negedge clk);
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        pend_a.push_back(imem_req_addr);
        pend_due.push_back(cyc + 1 + lat);
        req_log.push_back(imem_req_addr);
      end
      if (dec_valid && dec_ready) begin
        pop_pc.push_back(dec_pc);
        pop_in.push_back(dec_instr);
        pop_cyc.push_back(cyc + 1);
      end
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_a.size() > 0 && pend_due[0] == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic tick();
    half();
    step_edge();
  endtask

  task automatic rst_pulse();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend_a.delete();
    pend_due.delete();
    pop_pc.delete();
    pop_in.delete();
    pop_cyc.delete();
    req_log.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom;
      dec_ready      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst req_valid", 32'(imem_req_valid), 0);
      chk("rst req_addr", imem_req_addr, 32'h0);
      chk("rst dec_valid", 32'(dec_valid), 0);
      chk("rst dec_pc", dec_pc, 0);
      chk("rst dec_instr", dec_instr, 0);
      @(posedge clk);
      #1;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    rst            = 1'b0;

    // streaming, 1-cycle memory
    lat = 1;
    half();
    chk("first req valid", 32'(imem_req_valid), 1);
    chk("first req addr", imem_req_addr, 32'h0);
    step_edge();
    half();
    chk("second req addr", imem_req_addr, 32'h4);
    step_edge();
    repeat (10) tick();
    for (int i = 0; i < 6; i++) chk_pop("stream", i, 32'(4 * i));
    for (int i = 1; i < 6; i++)
      if (i < pop_cyc.size())
        chk("stream gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 1);

    // back-pressure
    rst_pulse();
    dec_ready = 1'b0;
    repeat (12) tick();
    chk("bp req count", 32'(req_log.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < req_log.size())
        chk("bp req addr", req_log[i], 32'(4 * i));
    half();
    chk("bp req_valid low", 32'(imem_req_valid), 0);
    step_edge();
    dec_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) chk_pop("bp pop", i, 32'(4 * i));
    if (req_log.size() > 4) chk("bp resume", req_log[4], 32'h10);
    else chk("bp resume missing", 32'(req_log.size()), 5);

    // redirect with two in-flight, 3-cycle memory
    rst_pulse();
    lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    half();
    chk("redir req_valid", 32'(imem_req_valid), 0);
    chk("redir dec_valid", 32'(dec_valid), 0);
    step_edge();
    redirect_valid = 1'b0;
    half();
    chk("redir new req", 32'(imem_req_valid), 1);
    chk("redir new addr", imem_req_addr, 32'h100);
    step_edge();
    repeat (10) tick();
    chk_pop("redir pop0", 0, 32'h100);
    chk_pop("redir pop1", 1, 32'h104);

    // redirect coinciding with a kept response
    rst_pulse();
    lat = 1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    half();
    chk("sim dec_valid", 32'(dec_valid), 0);
    step_edge();
    redirect_valid = 1'b0;
    half();
    chk("sim empty", 32'(dec_valid), 0);
    chk("sim aligned addr", imem_req_addr, 32'h100);
    step_edge();
    repeat (6) tick();
    chk_pop("sim pop0", 0, 32'h100);

    // bypass path (or one-cycle latency without it)
    rst_pulse();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_valid = 1'b0;
    half();
    chk("byp req addr", imem_req_addr, 32'h20);
    step_edge();
    imem_req_ready = 1'b0;
    half();
`ifdef FETCH_BYPASS_EN
    chk("byp same valid", 32'(dec_valid), 1);
    chk("byp same pc", dec_pc, 32'h20);
    chk("byp same instr", dec_instr, 32'h13);
`else
    chk("nobyp same valid", 32'(dec_valid), 0);
`endif
    step_edge();
    half();
`ifdef FETCH_BYPASS_EN
    chk("byp next valid", 32'(dec_valid), 0);
`else
    chk("nobyp next valid", 32'(dec_valid), 1);
    chk("nobyp next pc", dec_pc, 32'h20);
    chk("nobyp next instr", dec_instr, 32'h13);
`endif
    step_edge();
    imem_req_ready = 1'b1;

    // PC wrap
    rst_pulse();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    chk_pop("wrap0", 0, 32'hFFFF_FFF8);
    chk_pop("wrap1", 1, 32'hFFFF_FFFC);
    chk_pop("wrap2", 2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupled memory request/response interface, in-order outstanding-request tracking and a DEPTH-entry prefetch queue feeding decode through a valid/ready handshake. Sits between instruction memory and the decode stage. Redirects from decode (branch/JAL/JALR, already resolved to a target) flush the queue and discard in-flight responses. Stalls are expressed as back-pressure (`dec_ready` low) instead of a dedicated stall input.

## Interface
- `XLEN`, 32: address/instruction width.
- `DEPTH`, 4: queue entries and maximum in-flight requests; power of two, >= 2.
- `RESET_PC`, 0: first fetch address after reset; bits [1:0] must be 0.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out XLEN: word-aligned fetch address.
- `imem_rsp_valid` in 1: response data valid; in request order, latency >= 1, never back-pressured.
- `imem_rsp_data` in XLEN: instruction word.
- `redirect_valid` in 1: control-flow change; flush.
- `redirect_pc` in XLEN: new fetch target.
- `dec_valid` out 1: queue head valid toward decode.
- `dec_ready` in 1: decode consumes head.
- `dec_pc` out XLEN: PC of head instruction.
- `dec_instr` out XLEN: head instruction.

## Operation
- State: `fetch_pc` (next request address), `rsp_pc` (PC of next kept response), queue (`pc`, `instr` per entry, rd/wr pointers, `count` of width $clog2(DEPTH+1)), `outstanding` (same width), `drop_cnt` (same width).
- Request: `imem_req_valid` = !rst && !redirect_valid && (count + outstanding < DEPTH). On handshake: `fetch_pc` += 4, `outstanding` += 1.
- Response: `outstanding` -= 1. If `drop_cnt` != 0, the response is discarded and `drop_cnt` -= 1. Otherwise {`rsp_pc`, `imem_rsp_data`} is pushed and `rsp_pc` += 4. The credit rule guarantees a push never finds the queue full.
- Pop: `dec_valid` = (count != 0) && !redirect_valid. On `dec_valid && dec_ready`: read pointer advances and `count` -= 1.
- `dec_pc`/`dec_instr` are driven to 0 whenever `dec_valid` = 0.
- Redirect, with `redirect_valid` high at the edge:
  - Queue is emptied and pointers reset.
  - `fetch_pc` and `rsp_pc` are set to {`redirect_pc`[XLEN-1:2], 2'b00}; misaligned low bits are forced to zero.
  - `drop_cnt` is set to `outstanding` minus 1 if a response arrives in that same cycle, otherwise `outstanding`.
  - Any response arriving in the redirect cycle is discarded.
  - Redirect overrides push and pop in the same cycle.
- All PC arithmetic is modulo 2^XLEN; a wrap from 0xFFFFFFFC goes to 0.
- Reset values: `imem_req_valid` = 0, `imem_req_addr` = RESET_PC, `dec_valid` = 0, `dec_pc` = 0, `dec_instr` = 0.
  - Internal: count/outstanding/drop_cnt = 0, `fetch_pc` = `rsp_pc` = RESET_PC.
- Reset mid-operation discards all queue contents and in-flight tracking. Memory must also be reset, since stale responses after reset are not tracked.

## Timing
- `imem_req_addr` = `fetch_pc`, registered; stable while `imem_req_valid` is high and not accepted.
- A response at edge N appears on `dec_*` in cycle N+1 (one-cycle queue latency).
- With 1-cycle memory and `dec_ready` = 1, throughput is one instruction per cycle.
- Redirect at edge N: first new request issues in cycle N+1 with address = target.
- With `dec_ready` low, at most DEPTH requests issue before `imem_req_valid` drops.

## Configuration
- `FETCH_BYPASS_EN` defined: when `count` = 0, a kept response not coinciding with a redirect is presented combinationally on `dec_*` in the same cycle (`dec_valid` = 1).
  - If `dec_ready` is also high, it is consumed without a queue write.
  - Otherwise it is written to the queue as normal.
- `FETCH_BYPASS_EN` undefined: no combinational path from `imem_rsp_*` to `dec_*`; the one-cycle latency always applies.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with random inputs -> all outputs at reset values. Release with `imem_req_ready`=1 -> first request addr = RESET_PC, next 0x4.
- Streaming: 1-cycle memory, `dec_ready`=1 -> `dec_pc` sequence 0x0, 0x4, 0x8, ... on consecutive cycles, `dec_instr` matching memory words, no gaps.
- Back-pressure: `dec_ready`=0 for 12 cycles, DEPTH=4 -> exactly 4 requests (0x0..0xC), then `imem_req_valid`=0. Raise `dec_ready` -> pops 0x0, 0x4, 0x8, 0xC in order, fetch resumes at 0x10.
- Redirect with in-flight: 3-cycle memory, 2 outstanding, `redirect_pc`=0x100 -> both stale responses dropped, next `dec_pc` = 0x100, no 0x0/0x4 instruction reaches decode.
- Simultaneous: redirect in the same cycle as a kept response and `dec_ready`=1 -> response discarded, `dec_valid`=0 that cycle, queue empty after. Redirect to 0x103 -> `imem_req_addr` = 0x100.
- Bypass (`FETCH_BYPASS_EN`): empty queue, response 0x00000013 at PC 0x20 with `dec_ready`=1 -> `dec_valid`=1 same cycle, `count` stays 0. Without the macro -> appears one cycle later.
